// File: rtl/branch_flag_ctrl.sv
// Status flag register (Z,C,S,V) and conditional-branch sequencer: a taken
// branch issues a one-cycle PC redirect followed by a fixed fetch-flush window.
module branch_flag_ctrl #(
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        flag_we,
  input  logic [3:0]        flag_in,
  input  logic              br_valid,
  input  logic [2:0]        br_cond,
  input  logic [ADDR_W-1:0] br_target,
  output logic              br_ready,
  output logic              stall,
  output logic              pc_redirect,
  output logic [ADDR_W-1:0] pc_target,
  output logic              flush,
  output logic [3:0]        flags,
  output logic [15:0]       taken_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REDIRECT,
    ST_FLUSH
  } state_t;

  // Flush window = REDIRECT cycle + (FLUSH_CYCLES-1) FLUSH cycles.
  localparam logic [2:0] CNT_INIT = (FLUSH_CYCLES >= 2) ? 3'(FLUSH_CYCLES - 2) : 3'd0;

  state_t              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [3:0]          flags_q, flags_d;
  logic [ADDR_W-1:0]   pc_target_q, pc_target_d;
  logic [15:0]         taken_cnt_q, taken_cnt_d;

  // Flag order {V,S,C,Z}
  function automatic logic cond_met(input logic [2:0] cond, input logic [3:0] f);
    case (cond)
      3'b000:  return 1'b1;
      3'b001:  return f[0];
      3'b010:  return !f[0];
      3'b011:  return f[1];
      3'b100:  return !f[1];
      3'b101:  return f[2];
      3'b110:  return !f[2];
      default: return f[3];
    endcase
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    flags_d     = (flag_we & flag_in) | (~flag_we & flags_q);
    pc_target_d = pc_target_q;
    taken_cnt_d = taken_cnt_q;
    case (state_q)
      ST_IDLE: begin
        // Condition sees the flags from earlier instructions, not flag_in.
        if (br_valid && cond_met(br_cond, flags_q)) begin
          state_d     = ST_REDIRECT;
          pc_target_d = br_target;
          taken_cnt_d = sat_inc(taken_cnt_q);
        end
      end
      ST_REDIRECT: begin
        if (FLUSH_CYCLES <= 1) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FLUSH;
          cnt_d   = CNT_INIT;
        end
      end
      ST_FLUSH: begin
        if (cnt_q == 3'd0) state_d = ST_IDLE;
        else               cnt_d   = cnt_q - 3'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      flags_q     <= 4'd0;
      pc_target_q <= '0;
      taken_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      flags_q     <= flags_d;
      pc_target_q <= pc_target_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign br_ready    = (state_q == ST_IDLE);
  assign stall       = br_valid && !br_ready;
  assign pc_redirect = (state_q == ST_REDIRECT);
  assign flush       = (state_q != ST_IDLE);
  assign pc_target   = pc_target_q;
  assign flags       = flags_q;
  assign taken_cnt   = taken_cnt_q;

endmodule

// File: tb/tb_branch_flag_ctrl.sv
// Bench for branch_flag_ctrl: table of single-cycle vectors plus hand-written
// multi-cycle sequences, expectations queued at drive time and popped at sample.
module tb_branch_flag_ctrl;

  logic        clk;
  logic        rst;
  logic [3:0]  flag_we;
  logic [3:0]  flag_in;
  logic        br_valid;
  logic [2:0]  br_cond;
  logic [31:0] br_target;
  logic        br_ready;
  logic        stall;
  logic        pc_redirect;
  logic [31:0] pc_target;
  logic        flush;
  logic [3:0]  flags;
  logic [15:0] taken_cnt;

  branch_flag_ctrl #(.ADDR_W(32), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .flag_we(flag_we), .flag_in(flag_in),
    .br_valid(br_valid), .br_cond(br_cond), .br_target(br_target),
    .br_ready(br_ready), .stall(stall), .pc_redirect(pc_redirect),
    .pc_target(pc_target), .flush(flush), .flags(flags), .taken_cnt(taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  we;
    logic [3:0]  fin;
    logic        vld;
    logic [2:0]  cond;
    logic [31:0] tgt;
    logic [3:0]  e_flags;
    logic        e_taken;
    logic [31:0] e_tgt;
    logic [15:0] e_cnt;
  } vec_t;

  typedef struct {
    logic [3:0]  flags;
    logic        redir;
    logic        fl;
    logic        rdy;
    logic [31:0] tgt;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[15];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(input logic [3:0] we, input logic [3:0] fin, input logic vld,
                              input logic [2:0] cond, input logic [31:0] tgt,
                              input logic [3:0] ef, input logic et, input logic [31:0] etg,
                              input logic [15:0] ec);
    vec_t v;
    v.we = we; v.fin = fin; v.vld = vld; v.cond = cond; v.tgt = tgt;
    v.e_flags = ef; v.e_taken = et; v.e_tgt = etg; v.e_cnt = ec;
    return v;
  endfunction

  function automatic exp_t mke(input logic [3:0] f, input logic r, input logic fl,
                               input logic rdy, input logic [31:0] t, input logic [15:0] c);
    exp_t e;
    e.flags = f; e.redir = r; e.fl = fl; e.rdy = rdy; e.tgt = t; e.cnt = c;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic [3:0] we, input logic [3:0] fin, input logic vld,
                        input logic [2:0] cond, input logic [31:0] tgt);
    @(negedge clk);
    flag_we = we; flag_in = fin; br_valid = vld; br_cond = cond; br_target = tgt;
  endtask

  task automatic step(input string tag, input exp_t e);
    exp_t x;
    sb.push_back(e);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk({tag, ".flags"},       {28'd0, flags},  {28'd0, x.flags});
    chk({tag, ".pc_redirect"}, {31'd0, pc_redirect}, {31'd0, x.redir});
    chk({tag, ".flush"},       {31'd0, flush},  {31'd0, x.fl});
    chk({tag, ".br_ready"},    {31'd0, br_ready}, {31'd0, x.rdy});
    chk({tag, ".pc_target"},   pc_target,       x.tgt);
    chk({tag, ".taken_cnt"},   {16'd0, taken_cnt}, {16'd0, x.cnt});
  endtask

  // Two quiet cycles after a redirect: FLUSH, then back to IDLE.
  task automatic drain(input string tag, input logic [3:0] f, input logic [31:0] t,
                       input logic [15:0] c);
    set_in(4'd0, 4'd0, 1'b0, 3'd0, 32'd0);
    step({tag, ".fl"}, mke(f, 1'b0, 1'b1, 1'b0, t, c));
    step({tag, ".idle"}, mke(f, 1'b0, 1'b0, 1'b1, t, c));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; flag_we = 4'd0; flag_in = 4'd0; br_valid = 1'b0;
    br_cond = 3'd0; br_target = 32'd0;
    #2;
    chk("rst.flags",       {28'd0, flags}, 32'd0);
    chk("rst.pc_target",   pc_target, 32'd0);
    chk("rst.taken_cnt",   {16'd0, taken_cnt}, 32'd0);
    chk("rst.pc_redirect", {31'd0, pc_redirect}, 32'd0);
    chk("rst.flush",       {31'd0, flush}, 32'd0);
    chk("rst.br_ready",    {31'd0, br_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b1;

    //           we      fin     vld  cond    tgt      flags   tkn  e_tgt    cnt
    tbl[0]  = mk(4'b0101, 4'b1111, 0, 3'b000, 32'h0,  4'b0101, 0, 32'h0,  16'd0);
    tbl[1]  = mk(4'b0000, 4'b0000, 0, 3'b000, 32'h0,  4'b0101, 0, 32'h0,  16'd0);
    tbl[2]  = mk(4'b0000, 4'b0000, 1, 3'b001, 32'h40, 4'b0101, 1, 32'h40, 16'd1);
    tbl[3]  = mk(4'b0001, 4'b0000, 0, 3'b000, 32'h0,  4'b0100, 0, 32'h40, 16'd1);
    tbl[4]  = mk(4'b0000, 4'b0000, 1, 3'b001, 32'h80, 4'b0100, 0, 32'h40, 16'd1);
    tbl[5]  = mk(4'b0001, 4'b0001, 1, 3'b001, 32'h90, 4'b0101, 0, 32'h40, 16'd1);
    tbl[6]  = mk(4'b0000, 4'b0000, 1, 3'b001, 32'hA0, 4'b0101, 1, 32'hA0, 16'd2);
    tbl[7]  = mk(4'b1010, 4'b1010, 1, 3'b011, 32'hB0, 4'b1111, 0, 32'hA0, 16'd2);
    tbl[8]  = mk(4'b0000, 4'b0000, 1, 3'b100, 32'hB8, 4'b1111, 0, 32'hA0, 16'd2);
    tbl[9]  = mk(4'b0000, 4'b0000, 1, 3'b111, 32'hC0, 4'b1111, 1, 32'hC0, 16'd3);
    tbl[10] = mk(4'b1111, 4'b0000, 0, 3'b000, 32'h0,  4'b0000, 0, 32'hC0, 16'd3);
    tbl[11] = mk(4'b0000, 4'b0000, 1, 3'b010, 32'hD0, 4'b0000, 1, 32'hD0, 16'd4);
    tbl[12] = mk(4'b0000, 4'b0000, 1, 3'b110, 32'hE0, 4'b0000, 1, 32'hE0, 16'd5);
    tbl[13] = mk(4'b0000, 4'b0000, 1, 3'b101, 32'hE8, 4'b0000, 0, 32'hE0, 16'd5);
    tbl[14] = mk(4'b0000, 4'b0000, 1, 3'b000, 32'hF0, 4'b0000, 1, 32'hF0, 16'd6);

    for (int i = 0; i < 15; i++) begin
      set_in(tbl[i].we, tbl[i].fin, tbl[i].vld, tbl[i].cond, tbl[i].tgt);
      step($sformatf("vec%0d", i), mke(tbl[i].e_flags, tbl[i].e_taken, tbl[i].e_taken,
                                       !tbl[i].e_taken, tbl[i].e_tgt, tbl[i].e_cnt));
      if (tbl[i].e_taken)
        drain($sformatf("vec%0d", i), tbl[i].e_flags, tbl[i].e_tgt, tbl[i].e_cnt);
    end

    // br_valid held through the flush window: stalled, then accepted at first IDLE edge
    set_in(4'd0, 4'd0, 1'b1, 3'b000, 32'h100);
    step("b2b.acc", mke(4'd0, 1'b1, 1'b1, 1'b0, 32'h100, 16'd7));
    chk("b2b.stall_redir", {31'd0, stall}, 32'd1);
    set_in(4'd0, 4'd0, 1'b1, 3'b000, 32'h200);
    step("b2b.fl", mke(4'd0, 1'b0, 1'b1, 1'b0, 32'h100, 16'd7));
    chk("b2b.stall_flush", {31'd0, stall}, 32'd1);
    step("b2b.idle", mke(4'd0, 1'b0, 1'b0, 1'b1, 32'h100, 16'd7));
    chk("b2b.stall_idle", {31'd0, stall}, 32'd0);
    step("b2b.acc2", mke(4'd0, 1'b1, 1'b1, 1'b0, 32'h200, 16'd8));
    drain("b2b", 4'd0, 32'h200, 16'd8);

    // Counter saturation from a preset near the top
    @(negedge clk);
    force dut.taken_cnt_q = 16'hFFFD;
    @(posedge clk);
    #1;
    release dut.taken_cnt_q;
    chk("sat.preset", {16'd0, taken_cnt}, 32'h0000FFFD);
    for (int k = 0; k < 3; k++) begin
      logic [15:0] ec;
      logic [31:0] t;
      ec = (k == 0) ? 16'hFFFE : 16'hFFFF;
      t  = 32'h1000 + 32'(k);
      set_in(4'd0, 4'd0, 1'b1, 3'b000, t);
      step($sformatf("sat%0d", k), mke(4'd0, 1'b1, 1'b1, 1'b0, t, ec));
      drain($sformatf("sat%0d", k), 4'd0, t, ec);
    end

    // Asynchronous reset asserted in the middle of the FLUSH state
    set_in(4'b1111, 4'b1111, 1'b1, 3'b000, 32'h300);
    step("rmf.acc", mke(4'b1111, 1'b1, 1'b1, 1'b0, 32'h300, 16'hFFFF));
    set_in(4'd0, 4'd0, 1'b0, 3'd0, 32'd0);
    step("rmf.fl", mke(4'b1111, 1'b0, 1'b1, 1'b0, 32'h300, 16'hFFFF));
    #2;
    rst = 1'b0;
    #1;
    chk("rmf.flush",       {31'd0, flush}, 32'd0);
    chk("rmf.pc_redirect", {31'd0, pc_redirect}, 32'd0);
    chk("rmf.br_ready",    {31'd0, br_ready}, 32'd1);
    chk("rmf.flags",       {28'd0, flags}, 32'd0);
    chk("rmf.taken_cnt",   {16'd0, taken_cnt}, 32'd0);
    chk("rmf.pc_target",   pc_target, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    step("post_rst", mke(4'd0, 1'b0, 1'b0, 1'b1, 32'd0, 16'd0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
